// File: rtl/lc3b_alu_wb_if.sv
// Issue handshake, register-file read/write and status signals of the
// LC-3b execute/writeback stage, bundled for the stage and its environment.
interface lc3b_alu_wb_if;
    logic        issue_valid;
    logic        issue_ready;
    logic [15:0] instr;
    logic [15:0] pc;
    logic [2:0]  sr1;
    logic [2:0]  sr2;
    logic [15:0] sr1_out;
    logic [15:0] sr2_out;
    logic [2:0]  dr;
    logic [15:0] dr_in;
    logic        Write;
    logic [2:0]  nzp;
    logic        done;
    logic        err;

    // Environment side: issues instructions and returns register-file data.
    modport master (
        output issue_valid, instr, pc, sr1_out, sr2_out,
        input  issue_ready, sr1, sr2, dr, dr_in, Write, nzp, done, err
    );

    // Stage side.
    modport slave (
        input  issue_valid, instr, pc, sr1_out, sr2_out,
        output issue_ready, sr1, sr2, dr, dr_in, Write, nzp, done, err
    );
endinterface

// File: rtl/lc3b_alu_wb.sv
// LC-3b multicycle execute/writeback stage: IDLE -> READ -> EXEC -> WB.
// Latches one operate-class instruction, reads two register operands,
// computes the result, issues a single-cycle register-file write and keeps
// the NZP condition codes.
module lc3b_alu_wb #(
    parameter logic [2:0] NZP_RESET   = 3'b010,
    parameter bit         LEA_SETS_CC = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    lc3b_alu_wb_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_t;

    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_XOR = 4'b1001;
    localparam logic [3:0] OP_SHF = 4'b1101;
    localparam logic [3:0] OP_LEA = 4'b1110;

    state_t      state_q,  state_d;
    logic [15:0] instr_q,  instr_d;
    logic [15:0] pc_q,     pc_d;
    logic [15:0] opa_q,    opa_d;
    logic [15:0] opb_q,    opb_d;
    logic [15:0] result_q, result_d;
    logic [2:0]  dr_q,     dr_d;
    logic [15:0] dr_in_q,  dr_in_d;
    logic [2:0]  nzp_q,    nzp_d;

    logic [3:0]  opcode;
    logic        supported;
    logic        is_lea;
    logic        wb_write;
    logic [15:0] operand_b;
    logic [3:0]  shamt;
    logic [15:0] alu_result;
    logic [2:0]  result_cc;

    assign opcode    = instr_q[15:12];
    assign is_lea    = (opcode == OP_LEA);
    assign supported = (opcode == OP_ADD) || (opcode == OP_AND) ||
                       (opcode == OP_XOR) || (opcode == OP_SHF) || is_lea;
    assign operand_b = instr_q[5] ? {{11{instr_q[4]}}, instr_q[4:0]} : opb_q;
    assign shamt     = instr_q[3:0];

    // Result datapath; an unsupported opcode simply yields zero, which is never written.
    always_comb begin
        alu_result = '0;
        case (opcode)
            OP_ADD: alu_result = opa_q + operand_b;
            OP_AND: alu_result = opa_q & operand_b;
            OP_XOR: alu_result = opa_q ^ operand_b;
            OP_SHF: begin
                if (!instr_q[4])
                    alu_result = opa_q << shamt;
                else if (!instr_q[5])
                    alu_result = opa_q >> shamt;
                else
                    alu_result = unsigned'($signed(opa_q) >>> shamt);
            end
            OP_LEA: alu_result = pc_q + {{6{instr_q[8]}}, instr_q[8:0], 1'b0};
            default: alu_result = '0;
        endcase
    end

    // Condition codes of the result about to retire; always one-hot.
    always_comb begin
        if (result_q[15])
            result_cc = 3'b100;
        else if (result_q == 16'h0000)
            result_cc = 3'b010;
        else
            result_cc = 3'b001;
    end

    // Next-state and register-update logic for the four-cycle sequence.
    always_comb begin
        state_d  = state_q;
        instr_d  = instr_q;
        pc_d     = pc_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        result_d = result_q;
        dr_d     = dr_q;
        dr_in_d  = dr_in_q;
        nzp_d    = nzp_q;
        case (state_q)
            S_IDLE: begin
                if (bus.issue_valid) begin
                    instr_d = bus.instr;
                    pc_d    = bus.pc;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                opa_d   = bus.sr1_out;
                opb_d   = bus.sr2_out;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (supported)
                    result_d = alu_result;
                state_d = S_WB;
            end
            S_WB: begin
                if (supported) begin
                    dr_d    = instr_q[11:9];
                    dr_in_d = result_q;
                    if (!is_lea || LEA_SETS_CC)
                        nzp_d = result_cc;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset drops any in-flight instruction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            instr_q  <= '0;
            pc_q     <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            result_q <= '0;
            dr_q     <= '0;
            dr_in_q  <= '0;
            nzp_q    <= NZP_RESET;
        end else begin
            state_q  <= state_d;
            instr_q  <= instr_d;
            pc_q     <= pc_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            result_q <= result_d;
            dr_q     <= dr_d;
            dr_in_q  <= dr_in_d;
            nzp_q    <= nzp_d;
        end
    end

    // Destination and data are shown live during WB and held afterwards.
    assign wb_write        = (state_q == S_WB) && supported;
    assign bus.issue_ready = (state_q == S_IDLE);
    assign bus.sr1         = instr_q[8:6];
    assign bus.sr2         = instr_q[2:0];
    assign bus.Write       = wb_write;
    assign bus.dr          = wb_write ? instr_q[11:9] : dr_q;
    assign bus.dr_in       = wb_write ? result_q : dr_in_q;
    assign bus.nzp         = nzp_q;
    assign bus.done        = (state_q == S_WB);
    assign bus.err         = (state_q == S_WB) && !supported;
endmodule

// File: tb/tb_lc3b_alu_wb.sv
// Directed bench for lc3b_alu_wb with a behavioural 8x16 register file.
module tb_lc3b_alu_wb;
    logic clk;
    logic rst;
    lc3b_alu_wb_if bus ();

    lc3b_alu_wb #(.NZP_RESET(3'b010), .LEA_SETS_CC(1'b0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;
    int wr_cnt   = 0;
    int done_cnt = 0;
    int err_cnt  = 0;

    logic [15:0] rf [8];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file: combinational reads, write on the rising edge.
    assign bus.sr1_out = rf[bus.sr1];
    assign bus.sr2_out = rf[bus.sr2];
    always @(posedge clk) if (bus.Write) rf[bus.dr] <= bus.dr_in;

    // Pulse counters sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.Write) wr_cnt++;
        if (bus.done)  done_cnt++;
        if (bus.err)   err_cnt++;
    end

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        @(negedge clk);
        while (!bus.issue_ready && n < 8) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_ready"}, 16'(bus.issue_ready), 16'd1);
    endtask

    // Issues one instruction and checks every cycle of its 4-cycle trip.
    task automatic exec_instr(input string tag, input logic [15:0] ins, input logic [15:0] p,
                              input logic exp_wr, input logic [2:0] exp_dr,
                              input logic [15:0] exp_din, input logic [2:0] exp_nzp);
        int w0, d0;
        logic [2:0] s1;
        wait_ready(tag);
        w0 = wr_cnt;
        d0 = done_cnt;
        s1 = ins[8:6];
        bus.instr       = ins;
        bus.pc          = p;
        bus.issue_valid = 1'b1;
        @(posedge clk);
        #1 bus.issue_valid = 1'b0;
        @(negedge clk);
        check_eq({tag, "_read_wr"}, 16'(bus.Write), 16'd0);
        check_eq({tag, "_sr1"}, 16'(bus.sr1), 16'(s1));
        @(negedge clk);
        check_eq({tag, "_exec_done"}, 16'(bus.done), 16'd0);
        @(negedge clk);
        check_eq({tag, "_wb_wr"}, 16'(bus.Write), 16'(exp_wr));
        check_eq({tag, "_wb_done"}, 16'(bus.done), 16'd1);
        check_eq({tag, "_wb_err"}, 16'(bus.err), 16'(!exp_wr));
        check_eq({tag, "_dr"}, 16'(bus.dr), 16'(exp_dr));
        check_eq({tag, "_dr_in"}, bus.dr_in, exp_din);
        @(negedge clk);
        check_eq({tag, "_nzp"}, 16'(bus.nzp), 16'(exp_nzp));
        check_eq({tag, "_idle_ready"}, 16'(bus.issue_ready), 16'd1);
        check_eq({tag, "_wr_count"}, 16'(wr_cnt - w0), 16'(exp_wr));
        check_eq({tag, "_done_count"}, 16'(done_cnt - d0), 16'd1);
        $display("instr %s: instr=%h dr=%0d dr_in=%h nzp=%b", tag, ins, bus.dr, bus.dr_in, bus.nzp);
    endtask

    initial begin
        logic [15:0] b2b [3];
        int          acc [3];
        int          idx, w0, d0, e0;
        logic        hs;

        for (int i = 0; i < 8; i++) rf[i] = 16'h0000;
        rst = 1'b0;
        bus.issue_valid = 1'b0;
        bus.instr = 16'h0000;
        bus.pc = 16'h0000;
        repeat (3) @(negedge clk);
        check_eq("rst_nzp", 16'(bus.nzp), 16'h0002);
        check_eq("rst_ready", 16'(bus.issue_ready), 16'd1);
        check_eq("rst_write", 16'(bus.Write), 16'd0);
        check_eq("rst_done", 16'(bus.done), 16'd0);
        check_eq("rst_dr_in", bus.dr_in, 16'h0000);
        check_eq("rst_dr", 16'(bus.dr), 16'd0);
        rst = 1'b1;

        // ADD R3,R1,R2 with 5 + 0xFFFA
        rf[1] = 16'h0005;
        rf[2] = 16'hFFFA;
        exec_instr("add_reg", 16'h1642, 16'h0000, 1'b1, 3'd3, 16'hFFFF, 3'b100);
        check_eq("add_reg_rf3", rf[3], 16'hFFFF);

        // ADD R4,R1,#-1 with R1=1 wraps to zero; AND R5,R4,#15 stays zero
        rf[1] = 16'h0001;
        exec_instr("add_imm", 16'h187F, 16'h0000, 1'b1, 3'd4, 16'h0000, 3'b010);
        exec_instr("and_imm", 16'h5B2F, 16'h0000, 1'b1, 3'd5, 16'h0000, 3'b010);

        // Shifts of R6=0x8004 into R7
        rf[6] = 16'h8004;
        exec_instr("lshf1", 16'hDF81, 16'h0000, 1'b1, 3'd7, 16'h0008, 3'b001);
        exec_instr("rshfl2", 16'hDF92, 16'h0000, 1'b1, 3'd7, 16'h2001, 3'b001);
        exec_instr("rshfa2", 16'hDFB2, 16'h0000, 1'b1, 3'd7, 16'hE001, 3'b100);

        // LEA R0 with off9=0x1FF; NZP must stay 100
        exec_instr("lea", 16'hE1FF, 16'h3000, 1'b1, 3'd0, 16'h2FFE, 3'b100);

        // Reset during EXEC of ADD R5,R1,#1: no write may follow
        wait_ready("rst_mid");
        w0 = wr_cnt;
        bus.instr = 16'h1A61;
        bus.issue_valid = 1'b1;
        @(posedge clk);
        #1 bus.issue_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("rst_mid_nzp", 16'(bus.nzp), 16'h0002);
        check_eq("rst_mid_dr_in", bus.dr_in, 16'h0000);
        repeat (2) begin
            @(negedge clk);
            check_eq("rst_mid_write", 16'(bus.Write), 16'd0);
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_mid_ready", 16'(bus.issue_ready), 16'd1);
        check_eq("rst_mid_wr_count", 16'(wr_cnt - w0), 16'd0);
        check_eq("rst_mid_rf5", rf[5], 16'h0000);
        check_eq("rst_mid_nzp_after", 16'(bus.nzp), 16'h0002);
        $display("instr rst_mid: instr=1a61 dropped nzp=%b", bus.nzp);

        // Back-to-back with issue_valid held: ADD R3,R1,R2; ADD R2,R3,#2; illegal 0000
        rf[1] = 16'h0005;
        rf[2] = 16'hFFFA;
        b2b[0] = 16'h1642;
        b2b[1] = 16'h14E2;
        b2b[2] = 16'h0E00;
        acc[0] = 0; acc[1] = 0; acc[2] = 0;
        idx = 0;
        w0 = wr_cnt; d0 = done_cnt; e0 = err_cnt;
        @(negedge clk);
        for (int c = 0; c < 16; c++) begin
            if (idx < 3) begin
                bus.instr = b2b[idx];
                bus.issue_valid = 1'b1;
            end else begin
                bus.issue_valid = 1'b0;
            end
            hs = bus.issue_ready && bus.issue_valid;
            @(posedge clk);
            if (hs) begin
                acc[idx] = c;
                $display("instr b2b accept %0d: instr=%h cycle=%0d", idx, b2b[idx], c);
                idx++;
            end
            @(negedge clk);
        end
        check_eq("b2b_accepts", 16'(idx), 16'd3);
        check_eq("b2b_gap1", 16'(acc[1] - acc[0]), 16'd4);
        check_eq("b2b_gap2", 16'(acc[2] - acc[1]), 16'd4);
        check_eq("b2b_writes", 16'(wr_cnt - w0), 16'd2);
        check_eq("b2b_dones", 16'(done_cnt - d0), 16'd3);
        check_eq("b2b_errs", 16'(err_cnt - e0), 16'd1);
        check_eq("b2b_rf3", rf[3], 16'hFFFF);
        check_eq("b2b_raw_rf2", rf[2], 16'h0001);
        check_eq("b2b_nzp", 16'(bus.nzp), 16'h0001);
        check_eq("b2b_dr_hold", 16'(bus.dr), 16'd2);
        check_eq("b2b_dr_in_hold", bus.dr_in, 16'h0001);

        // Illegal opcode alone: done & err, no write, state held
        exec_instr("illegal", 16'h0000, 16'h0000, 1'b0, 3'd2, 16'h0001, 3'b001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
